ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//   Shares the single data RAM (RAMcs/RAMrd/RAMwr) between the CPU control path and a DMA/IO port.
//   Round-robin arbitration; each grant performs one RAM access with RAM_WAIT wait cycles.
//   The DMA port may burst up to DMA_MAX_BURST accesses when the CPU is not requesting.
//   Sits between the control-signal decode (RAM strobes) and the ram module.
// PARAMETERS
//   ADDR_W         8  RAM address width
//   DATA_W         8  RAM data width
//   RAM_WAIT       1  extra cycles ram_cs/strobe are held per access (0..7)
//   DMA_MAX_BURST  4  max back-to-back DMA accesses per grant (1..15)
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   cpu_req    in   1       CPU access request, level, held until cpu_done
//   cpu_wr     in   1       1 = write, 0 = read
//   cpu_addr   in   ADDR_W  CPU address
//   cpu_wdata  in   DATA_W  CPU write data
//   cpu_gnt    out  1       CPU owns RAM (ACCESS/DONE states)
//   cpu_done   out  1       one-cycle pulse: CPU access complete, cpu_rdata valid
//   cpu_rdata  out  DATA_W  read data, held until next CPU read completes
//   dma_req, dma_wr, dma_addr, dma_wdata, dma_gnt, dma_done, dma_rdata  same as cpu_*, DMA side
//   ram_cs     out  1       RAM chip select
//   ram_rd     out  1       RAM read strobe
//   ram_wr     out  1       RAM write strobe
//   ram_addr   out  ADDR_W  RAM address
//   ram_wdata  out  DATA_W  RAM write data
//   ram_rdata  in   DATA_W  RAM read data
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0, last_owner=DMA (CPU wins first tie), burst_cnt=0, wait_cnt=0.
//   States: IDLE, ACCESS, DONE. All outputs registered.
//   IDLE: pick owner at edge: only one req -> that one; both -> requester != last_owner.
//     Latch wr/addr/wdata of owner into ram_* regs; wait_cnt=RAM_WAIT; -> ACCESS. No req -> stay.
//   ACCESS: ram_cs=1, ram_rd=~wr, ram_wr=wr, owner gnt=1; decrement wait_cnt each cycle;
//     at wait_cnt==0: capture ram_rdata (reads only) into owner rdata; -> DONE.
//     ACCESS lasts exactly RAM_WAIT+1 cycles.
//   DONE (1 cycle): owner done=1, gnt=1, ram_* strobes 0; last_owner=owner; burst_cnt++ (DMA only).
//     DMA owner, dma_req=1, cpu_req=0, burst_cnt<DMA_MAX_BURST -> re-latch DMA inputs, -> ACCESS.
//     Otherwise burst_cnt=0, -> IDLE.
//   Latency: req sampled at edge k -> done high in cycle k+RAM_WAIT+2; next IDLE grant at k+RAM_WAIT+3.
//   Burst access-to-access period RAM_WAIT+2 cycles; cpu_req seen in DONE ends burst,
//     CPU then wins the IDLE tie (last_owner=DMA).
//   Requester drops req mid-ACCESS: access still completes, done still pulses.
//   Inputs changing during ACCESS have no effect (latched at grant).
//   Non-owner rdata unchanged by another port's access; writes leave both rdata unchanged.
//   rst_n low at any time: immediate return to reset values, ram_cs/strobes drop asynchronously,
//     in-flight access aborted with no done pulse.
// TESTING
//   CPU read addr 0x10 (RAM=0x5A), RAM_WAIT=1 -> ram_cs/ram_rd high 2 cycles, cpu_done at k+3, cpu_rdata=0x5A.
//   cpu_req and dma_req same edge after reset -> CPU served first, DMA granted at k+4 (RAM_WAIT=1).
//   DMA write burst, dma_req held, cpu_req=0 -> exactly 4 ram_wr pulses, 3 cycles apart, then IDLE.
//   cpu_req raised during 2nd DMA access -> DMA burst stops after 2, next grant is CPU.
//   RAM_WAIT=0 CPU write 0xA5 to 0x03 -> ram_wr one cycle, cpu_done at k+2, RAM[0x03]=0xA5.
//   rst_n pulsed low mid-ACCESS -> ram_cs=0 immediately, no done, busy=0; next req served normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one data RAM between the CPU control path and a DMA/IO port.
//   Round-robin arbitration between the two ports; every grant performs one
//   RAM access lasting RAM_WAIT+1 cycles, followed by a one-cycle DONE state.
//   While the CPU is idle, the DMA port may chain up to DMA_MAX_BURST accesses
//   back to back without returning to IDLE.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   cpu_req/wr/addr/wdata            CPU request, level, held until cpu_done
//   cpu_gnt/done/rdata               CPU owns RAM / completion pulse / read data
//   dma_*                            same set for the DMA port
//   ram_cs/rd/wr/addr/wdata          RAM interface (all registered)
//   ram_rdata                        RAM read data
//   busy                             arbiter not idle
module ram_arbiter #(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 8,
   parameter int RAM_WAIT      = 1,
   parameter int DMA_MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_req,
   input  logic              dma_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_done,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              ram_cs,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT);
   localparam logic [3:0] BURST_MAX = 4'(DMA_MAX_BURST);

   // owner / last_owner encoding: 1 = DMA, 0 = CPU
   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_owner_reg, last_owner_next;
   logic [2:0]        wait_cnt_reg, wait_cnt_next;
   logic [3:0]        burst_cnt_reg, burst_cnt_next;
   logic              wr_reg, wr_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
   logic [DATA_W-1:0] dma_rdata_reg, dma_rdata_next;
   logic              ram_cs_reg, ram_cs_next;
   logic              ram_rd_reg, ram_rd_next;
   logic              ram_wr_reg, ram_wr_next;
   logic              cpu_gnt_reg, cpu_gnt_next;
   logic              cpu_done_reg, cpu_done_next;
   logic              dma_gnt_reg, dma_gnt_next;
   logic              dma_done_reg, dma_done_next;
   logic              busy_reg, busy_next;
   logic              pick_dma;
   logic [3:0]        burst_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;   // DMA, so the CPU wins the first tie
         wait_cnt_reg   <= '0;
         burst_cnt_reg  <= '0;
         wr_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         cpu_rdata_reg  <= '0;
         dma_rdata_reg  <= '0;
         ram_cs_reg     <= 1'b0;
         ram_rd_reg     <= 1'b0;
         ram_wr_reg     <= 1'b0;
         cpu_gnt_reg    <= 1'b0;
         cpu_done_reg   <= 1'b0;
         dma_gnt_reg    <= 1'b0;
         dma_done_reg   <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         wait_cnt_reg   <= wait_cnt_next;
         burst_cnt_reg  <= burst_cnt_next;
         wr_reg         <= wr_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         cpu_rdata_reg  <= cpu_rdata_next;
         dma_rdata_reg  <= dma_rdata_next;
         ram_cs_reg     <= ram_cs_next;
         ram_rd_reg     <= ram_rd_next;
         ram_wr_reg     <= ram_wr_next;
         cpu_gnt_reg    <= cpu_gnt_next;
         cpu_done_reg   <= cpu_done_next;
         dma_gnt_reg    <= dma_gnt_next;
         dma_done_reg   <= dma_done_next;
         busy_reg       <= busy_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      wait_cnt_next   = wait_cnt_reg;
      burst_cnt_next  = burst_cnt_reg;
      wr_next         = wr_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      cpu_rdata_next  = cpu_rdata_reg;
      dma_rdata_next  = dma_rdata_reg;
      burst_inc       = burst_cnt_reg + 4'd1;
      // DMA wins only if the CPU is not asking, or the CPU was served last
      pick_dma        = dma_req & (~cpu_req | ~last_owner_reg);

      case (state_reg)
         ST_IDLE: begin
            if (cpu_req | dma_req) begin
               owner_next    = pick_dma;
               wr_next       = pick_dma ? dma_wr    : cpu_wr;
               addr_next     = pick_dma ? dma_addr  : cpu_addr;
               wdata_next    = pick_dma ? dma_wdata : cpu_wdata;
               wait_cnt_next = WAIT_INIT;
               state_next    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (wait_cnt_reg == 3'd0) begin
               if (!wr_reg) begin
                  if (owner_reg) dma_rdata_next = ram_rdata;
                  else           cpu_rdata_next = ram_rdata;
               end
               state_next = ST_DONE;
            end else begin
               wait_cnt_next = wait_cnt_reg - 3'd1;
            end
         end
         ST_DONE: begin
            last_owner_next = owner_reg;
            // burst_inc counts the access just finished
            if (owner_reg && dma_req && !cpu_req && (burst_inc < BURST_MAX)) begin
               wr_next        = dma_wr;
               addr_next      = dma_addr;
               wdata_next     = dma_wdata;
               wait_cnt_next  = WAIT_INIT;
               burst_cnt_next = burst_inc;
               state_next     = ST_ACCESS;
            end else begin
               burst_cnt_next = '0;
               state_next     = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they come straight from flops.
      ram_cs_next   = (state_next == ST_ACCESS);
      ram_rd_next   = (state_next == ST_ACCESS) & ~wr_next;
      ram_wr_next   = (state_next == ST_ACCESS) &  wr_next;
      cpu_gnt_next  = (state_next != ST_IDLE) & ~owner_next;
      dma_gnt_next  = (state_next != ST_IDLE) &  owner_next;
      cpu_done_next = (state_next == ST_DONE) & ~owner_next;
      dma_done_next = (state_next == ST_DONE) &  owner_next;
      busy_next     = (state_next != ST_IDLE);
   end

   assign cpu_gnt   = cpu_gnt_reg;
   assign cpu_done  = cpu_done_reg;
   assign cpu_rdata = cpu_rdata_reg;
   assign dma_gnt   = dma_gnt_reg;
   assign dma_done  = dma_done_reg;
   assign dma_rdata = dma_rdata_reg;
   assign ram_cs    = ram_cs_reg;
   assign ram_rd    = ram_rd_reg;
   assign ram_wr    = ram_wr_reg;
   assign ram_addr  = addr_reg;
   assign ram_wdata = wdata_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT with RAM_WAIT=1 ----------------
   logic       cpu_req = 0, cpu_wr = 0, dma_req = 0, dma_wr = 0;
   logic [7:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
   logic       cpu_gnt, cpu_done, dma_gnt, dma_done;
   logic [7:0] cpu_rdata, dma_rdata;
   logic       ram_cs, ram_rd, ram_wr, busy;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_WAIT(1), .DMA_MAX_BURST(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
      .ram_cs(ram_cs), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   logic       preload = 1'b1;
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (preload) begin
         mem[8'h10] <= 8'h5A;
         mem[8'h20] <= 8'hC3;
         mem[8'h21] <= 8'h3C;
         mem[8'h30] <= 8'h00;
      end else if (ram_cs && ram_wr) begin
         mem[ram_addr] <= ram_wdata;
      end
   end
   assign ram_rdata = mem[ram_addr];

   // ---------------- DUT with RAM_WAIT=0 ----------------
   logic       z_cpu_req = 0, z_cpu_wr = 0;
   logic [7:0] z_cpu_addr = 0, z_cpu_wdata = 0;
   logic       z_dma_req = 0, z_dma_wr = 0;
   logic [7:0] z_dma_addr = 0, z_dma_wdata = 0;
   logic       z_cpu_gnt, z_cpu_done, z_dma_gnt, z_dma_done;
   logic [7:0] z_cpu_rdata, z_dma_rdata;
   logic       z_ram_cs, z_ram_rd, z_ram_wr, z_busy;
   logic [7:0] z_ram_addr, z_ram_wdata, z_ram_rdata;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_WAIT(0), .DMA_MAX_BURST(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(z_cpu_req), .cpu_wr(z_cpu_wr), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
      .cpu_gnt(z_cpu_gnt), .cpu_done(z_cpu_done), .cpu_rdata(z_cpu_rdata),
      .dma_req(z_dma_req), .dma_wr(z_dma_wr), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
      .dma_gnt(z_dma_gnt), .dma_done(z_dma_done), .dma_rdata(z_dma_rdata),
      .ram_cs(z_ram_cs), .ram_rd(z_ram_rd), .ram_wr(z_ram_wr), .ram_addr(z_ram_addr),
      .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata), .busy(z_busy)
   );

   logic [7:0] mem0 [0:255];
   always @(posedge clk) begin
      if (z_ram_cs && z_ram_wr) mem0[z_ram_addr] <= z_ram_wdata;
   end
   assign z_ram_rdata = mem0[z_ram_addr];

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // flags = {ram_cs, ram_rd, ram_wr, cpu_gnt, cpu_done, dma_gnt, dma_done, busy}
   function automatic logic [7:0] flags();
      return {ram_cs, ram_rd, ram_wr, cpu_gnt, cpu_done, dma_gnt, dma_done, busy};
   endfunction

   typedef struct {
      logic       c_req;
      logic [7:0] c_addr;
      logic       d_req;
      logic [7:0] d_addr;
      logic [7:0] exp_flags;
      logic [7:0] exp_crd;
      logic [7:0] exp_drd;
   } vec_t;

   vec_t vecs [12];

   task automatic apply(input vec_t v);
      cpu_req  = v.c_req;  cpu_wr = 1'b0; cpu_addr = v.c_addr;
      dma_req  = v.d_req;  dma_wr = 1'b0; dma_addr = v.d_addr;
   endtask

   initial begin
      int n;
      int rises;
      int rise_at [4];
      int dcount;
      logic prev_wr;
      logic got;
      logic seen;

      // read tie, DMA after CPU, CPU read with address changing mid-access
      vecs[0]  = '{1, 8'h20, 1, 8'h21, 8'b1101_0001, 8'h00, 8'h00};
      vecs[1]  = '{1, 8'h20, 1, 8'h21, 8'b1101_0001, 8'h00, 8'h00};
      vecs[2]  = '{1, 8'h20, 1, 8'h21, 8'b0001_1001, 8'hC3, 8'h00};
      vecs[3]  = '{0, 8'h00, 1, 8'h21, 8'b0000_0000, 8'hC3, 8'h00};
      vecs[4]  = '{0, 8'h00, 1, 8'h21, 8'b1100_0101, 8'hC3, 8'h00};
      vecs[5]  = '{0, 8'h00, 1, 8'h21, 8'b1100_0101, 8'hC3, 8'h00};
      vecs[6]  = '{0, 8'h00, 1, 8'h21, 8'b0000_0111, 8'hC3, 8'h3C};
      vecs[7]  = '{0, 8'h00, 0, 8'h00, 8'b0000_0000, 8'hC3, 8'h3C};
      vecs[8]  = '{1, 8'h10, 0, 8'h00, 8'b1101_0001, 8'hC3, 8'h3C};
      vecs[9]  = '{1, 8'h20, 0, 8'h00, 8'b1101_0001, 8'hC3, 8'h3C};
      vecs[10] = '{1, 8'h20, 0, 8'h00, 8'b0001_1001, 8'h5A, 8'h3C};
      vecs[11] = '{0, 8'h00, 0, 8'h00, 8'b0000_0000, 8'h5A, 8'h3C};

      // reset
      repeat (2) @(negedge clk);
      preload = 1'b0;
      chk("reset_flags", 32'(flags()), 32'h0);
      chk("reset_rdata", {16'h0, cpu_rdata, dma_rdata}, 32'h0);
      chk("reset_dut0", {29'h0, z_ram_cs, z_busy, z_cpu_done}, 32'h0);
      rst_n = 1'b1;

      // table-driven vectors
      apply(vecs[0]);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].exp_flags));
         chk($sformatf("vec%0d_crd", i), 32'(cpu_rdata), 32'(vecs[i].exp_crd));
         chk($sformatf("vec%0d_drd", i), 32'(dma_rdata), 32'(vecs[i].exp_drd));
         $display("txn vec%0d flags=%b cpu_rdata=%h dma_rdata=%h", i, flags(), cpu_rdata, dma_rdata);
         if (i < 11) apply(vecs[i+1]);
      end

      // DMA write burst: 4 accesses, rising ram_wr every 3 cycles, then IDLE
      dma_req = 1; dma_wr = 1; dma_addr = 8'h30; dma_wdata = 8'h11;
      rises = 0; dcount = 0; prev_wr = 0; got = 0;
      for (n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (ram_wr && !prev_wr) begin
            if (rises < 4) rise_at[rises] = n;
            rises++;
         end
         prev_wr = ram_wr;
         if (dma_done) dcount++;
         if (dcount == 4) begin got = 1; break; end
      end
      chk("burst_complete", 32'(got), 32'h1);
      chk("burst_wr_pulses", 32'(rises), 32'd4);
      for (int i = 1; i < 4; i++)
         chk($sformatf("burst_gap%0d", i), 32'(rise_at[i] - rise_at[i-1]), 32'd3);
      @(negedge clk);
      chk("burst_then_idle", {30'h0, busy, ram_cs}, 32'h0);
      dma_req = 0; dma_wr = 0;
      chk("burst_mem", 32'(mem[8'h30]), 32'h11);
      $display("txn dma_burst pulses=%0d done=%0d", rises, dcount);
      @(negedge clk);

      // CPU request during 2nd DMA access ends the burst after 2 accesses
      dma_req = 1; dma_wr = 0; dma_addr = 8'h21;
      dcount = 0; got = 0; seen = 0;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (dma_done) dcount++;
         if (cpu_gnt) begin
            got = 1;
            seen = dma_gnt;
            break;
         end
         if (dcount == 1 && dma_gnt && ram_cs && !cpu_req) begin
            cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h10;
         end
      end
      dma_req = 0;
      chk("preempt_cpu_granted", 32'(got), 32'h1);
      chk("preempt_dma_count", 32'(dcount), 32'd2);
      chk("preempt_dma_gnt_low", 32'(seen), 32'h0);
      got = 0;
      for (n = 0; n < 10; n++) begin
         if (cpu_done) begin got = 1; break; end
         @(negedge clk);
      end
      chk("preempt_cpu_done", 32'(got), 32'h1);
      chk("preempt_cpu_rdata", 32'(cpu_rdata), 32'h5A);
      cpu_req = 0;
      $display("txn dma_preempt dma_accesses=%0d cpu_rdata=%h", dcount, cpu_rdata);
      @(negedge clk);

      // async reset mid-access
      cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h20;
      @(negedge clk);
      chk("rst_access_active", 32'(ram_cs), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_drop", {29'h0, ram_cs, busy, cpu_gnt}, 32'h0);
      cpu_req = 0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (cpu_done || busy) seen = 1;
      end
      chk("rst_no_done", 32'(seen), 32'h0);
      cpu_req = 1; cpu_addr = 8'h10;
      got = 0;
      for (n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (cpu_done) begin got = 1; break; end
      end
      chk("rst_next_latency", 32'(n), 32'd3);
      chk("rst_next_rdata", 32'(cpu_rdata), 32'h5A);
      cpu_req = 0;
      $display("txn reset_recover latency=%0d cpu_rdata=%h", n, cpu_rdata);
      @(negedge clk);

      // RAM_WAIT=0 CPU write
      z_cpu_req = 1; z_cpu_wr = 1; z_cpu_addr = 8'h03; z_cpu_wdata = 8'hA5;
      @(negedge clk);
      chk("w0_access", {29'h0, z_ram_wr, z_ram_cs, z_cpu_done}, 32'h6);
      @(negedge clk);
      chk("w0_done", {29'h0, z_ram_wr, z_cpu_gnt, z_cpu_done}, 32'h3);
      z_cpu_req = 0;
      @(negedge clk);
      chk("w0_idle", 32'(z_busy), 32'h0);
      chk("w0_mem", 32'(mem0[8'h03]), 32'hA5);
      $display("txn wait0_write mem[03]=%h", mem0[8'h03]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
